// File: rtl/counter_seq_checker_pkg.sv
// Shared types and helpers for counter_seq_checker and its saturating counters.
// State encodings are fixed so that external probes and waveforms agree on their meaning.
package counter_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Wide enough for any lock length in 1..15.
    localparam int GOOD_W = 4;

    // Increments v, but holds it once it reaches the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_val;
        max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_val) ? max_val : (v + 32'd1);
    endfunction

endpackage

// File: rtl/counter_seq_checker_sat_counter.sv
// sat_counter: W-bit up-counter that saturates at all-ones; asynchronous active-low reset.
module sat_counter
    import counter_seq_checker_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (inc) begin
            q <= W'(sat_inc(32'(q), W));
        end
    end

endmodule

// File: rtl/counter_seq_checker.sv
// counter_seq_checker: locks onto an observed up-counter stream and flags illegal steps.
// Optional build macro CNT_CHK_WRAP_STAT_EN adds the wrap_count statistics output.
module counter_seq_checker
    import counter_seq_checker_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 2,
    parameter int ERRC_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  q_in,
    input  logic              q_valid,
    input  logic              dut_clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERRC_W-1:0] err_count,
`ifdef CNT_CHK_WRAP_STAT_EN
    output logic [ERRC_W-1:0] wrap_count,
`endif
    output logic [WIDTH-1:0]  expected
);

    state_t            state;
    state_t            state_nxt;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_nxt;
    logic [GOOD_W-1:0] good_inc;
    logic [WIDTH-1:0]  exp_q;
    logic [WIDTH-1:0]  exp_d;
    logic [WIDTH-1:0]  cmp_val;
    logic [WIDTH-1:0]  seed;
    logic              match;
    logic              clr_pend;
    logic              clr_pend_d;
    logic              err_d;

    // A pending clear overrides the running prediction: the next sample must be 0.
    assign cmp_val    = clr_pend ? '0 : exp_q;
    assign match      = (q_in == cmp_val);
    assign seed       = dut_clr ? '0 : (q_in + WIDTH'(1));
    assign good_inc   = good + GOOD_W'(1);
    assign clr_pend_d = dut_clr | (clr_pend & ~q_valid);

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        exp_d     = exp_q;
        err_d     = 1'b0;
        if (q_valid) begin
            exp_d = seed;
            case (state)
                ST_UNLOCKED: begin
                    state_nxt = ST_ACQUIRE;
                    good_nxt  = '0;
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        good_nxt = good_inc;
                        if (good_inc >= GOOD_W'(LOCK_LEN)) begin
                            state_nxt = ST_LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    err_d = ~match;
                end
                default: begin
                    state_nxt = ST_UNLOCKED;
                    good_nxt  = '0;
                end
            endcase
        end else if (dut_clr) begin
            exp_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_UNLOCKED;
            good       <= '0;
            exp_q      <= '0;
            clr_pend   <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            good       <= good_nxt;
            exp_q      <= exp_d;
            clr_pend   <= clr_pend_d;
            err_pulse  <= err_d;
            err_sticky <= err_sticky | err_d;
        end
    end

    assign locked   = (state == ST_LOCKED);
    assign expected = exp_q;

    sat_counter #(.W(ERRC_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_d),
        .q     (err_count)
    );

`ifdef CNT_CHK_WRAP_STAT_EN
    // A matched 0 with no clear pending can only follow an all-ones sample.
    logic wrap_hit;
    assign wrap_hit = q_valid && (state == ST_LOCKED) && match && !clr_pend && (exp_q == '0);

    sat_counter #(.W(ERRC_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_hit),
        .q     (wrap_count)
    );
`endif

endmodule
